// File: rtl/tdm_demux_1to4.sv
// Registered 1-to-4 TDM demultiplexer: aligns slot 0 on frame_start, steers words
// to four channel registers and publishes a snapshot of every complete frame.
module tdm_demux_1to4 #(
  parameter int width = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [width-1:0]   din,
  input  logic               din_valid,
  input  logic               frame_start,
  output logic [width-1:0]   ch0,
  output logic [width-1:0]   ch1,
  output logic [width-1:0]   ch2,
  output logic [width-1:0]   ch3,
  output logic [3:0]         ch_valid,
  output logic [4*width-1:0] frame_out,
  output logic               frame_done,
  output logic               sync_err,
  output logic               busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q;
  logic [1:0]         slot_q;
  logic [width-1:0]   ch0_q, ch1_q, ch2_q, ch3_q;
  logic [3:0]         ch_valid_q;
  logic [4*width-1:0] frame_q;
  logic               frame_done_q, sync_err_q, busy_q;

  // Frame alignment FSM, channel steering and pulse generation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      slot_q       <= 2'd0;
      ch0_q        <= '0;
      ch1_q        <= '0;
      ch2_q        <= '0;
      ch3_q        <= '0;
      ch_valid_q   <= 4'b0000;
      frame_q      <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ch_valid_q   <= 4'b0000;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (din_valid) begin
        case (state_q)
          IDLE: begin
            if (frame_start) begin
              ch0_q      <= din;
              ch_valid_q <= 4'b0001;
              slot_q     <= 2'd1;
              state_q    <= RUN;
              busy_q     <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
          RUN: begin
            if (frame_start) begin
              // Resync: abandon the partial frame, stale ch1..ch3 are kept
              sync_err_q <= 1'b1;
              ch0_q      <= din;
              ch_valid_q <= 4'b0001;
              slot_q     <= 2'd1;
            end else begin
              ch_valid_q <= 4'b0001 << slot_q;
              case (slot_q)
                2'd1: begin
                  ch1_q  <= din;
                  slot_q <= 2'd2;
                end
                2'd2: begin
                  ch2_q  <= din;
                  slot_q <= 2'd3;
                end
                2'd3: begin
                  ch3_q        <= din;
                  frame_q      <= {din, ch2_q, ch1_q, ch0_q};
                  frame_done_q <= 1'b1;
                  slot_q       <= 2'd0;
                  state_q      <= IDLE;
                  busy_q       <= 1'b0;
                end
                default: begin
                  slot_q  <= 2'd0;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                end
              endcase
            end
          end
          default: begin
            state_q <= IDLE;
            slot_q  <= 2'd0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ch0        = ch0_q;
  assign ch1        = ch1_q;
  assign ch2        = ch2_q;
  assign ch3        = ch3_q;
  assign ch_valid   = ch_valid_q;
  assign frame_out  = frame_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Self-checking bench for tdm_demux_1to4: directed vector table with hand-derived
// expectations, then random traffic against a frame-queue reference model.
module tb_tdm_demux_1to4;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   din = '0;
  logic           din_valid = 1'b0;
  logic           frame_start = 1'b0;
  logic [W-1:0]   ch0, ch1, ch2, ch3;
  logic [3:0]     ch_valid;
  logic [4*W-1:0] frame_out;
  logic           frame_done, sync_err, busy;

  int n_vec = 0;
  int n_bad = 0;

  tdm_demux_1to4 #(.width(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_start(frame_start),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch_valid(ch_valid),
    .frame_out(frame_out), .frame_done(frame_done), .sync_err(sync_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           r, v, fs;
    logic [W-1:0]   d;
    logic [3:0]     cv;
    logic           dn, er, b;
    logic [4*W-1:0] fr;
  } vec_t;

  vec_t tbl[$];

  // Reference model: the partial frame is a queue of words received since frame_start
  logic [W-1:0]   m_ch[4];
  logic [4*W-1:0] m_frame;
  logic [3:0]     m_cv;
  logic           m_done, m_err, m_busy;
  logic [W-1:0]   part[$];

  task automatic model_step(input logic r, input logic v, input logic fs, input logic [W-1:0] d);
    int idx;
    m_cv = 4'b0000;
    m_done = 1'b0;
    m_err = 1'b0;
    if (r) begin
      for (int k = 0; k < 4; k++) m_ch[k] = '0;
      m_frame = '0;
      part.delete();
    end else if (v) begin
      if (fs) begin
        if (part.size() != 0) m_err = 1'b1;
        part.delete();
        part.push_back(d);
        m_ch[0] = d;
        m_cv = 4'b0001;
      end else if (part.size() != 0) begin
        idx = part.size();
        m_ch[idx] = d;
        m_cv[idx] = 1'b1;
        part.push_back(d);
        if (part.size() == 4) begin
          m_frame = {part[3], part[2], part[1], part[0]};
          m_done = 1'b1;
          part.delete();
        end
      end
    end
    m_busy = (part.size() != 0);
  endtask

  task automatic chk(input string name, input logic [4*W-1:0] act, input logic [4*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("ch0", 64'(ch0), 64'(m_ch[0]));
    chk("ch1", 64'(ch1), 64'(m_ch[1]));
    chk("ch2", 64'(ch2), 64'(m_ch[2]));
    chk("ch3", 64'(ch3), 64'(m_ch[3]));
    chk("ch_valid", 64'(ch_valid), 64'(m_cv));
    chk("frame_out", frame_out, m_frame);
    chk("frame_done", 64'(frame_done), 64'(m_done));
    chk("sync_err", 64'(sync_err), 64'(m_err));
    chk("busy", 64'(busy), 64'(m_busy));
  endtask

  task automatic step(input logic r, input logic v, input logic fs, input logic [W-1:0] d);
    rst = r;
    din_valid = v;
    frame_start = fs;
    din = d;
    @(posedge clk);
    #1;
    model_step(r, v, fs, d);
    check_model();
  endtask

  function automatic void add(input logic r, input logic v, input logic fs, input logic [W-1:0] d,
                              input logic [3:0] cv, input logic dn, input logic er, input logic b,
                              input logic [4*W-1:0] fr);
    vec_t x;
    x.r = r; x.v = v; x.fs = fs; x.d = d;
    x.cv = cv; x.dn = dn; x.er = er; x.b = b; x.fr = fr;
    tbl.push_back(x);
  endfunction

  function automatic void add_gaps(input logic [4*W-1:0] fr, input logic with_fs);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b1, fr);
    add(1'b0, 1'b0, with_fs, 16'hFFFF, 4'b0000, 1'b0, 1'b0, 1'b1, fr);
    add(1'b0, 1'b0, 1'b0, 16'h5555, 4'b0000, 1'b0, 1'b0, 1'b1, fr);
  endfunction

  initial begin
    logic [4*W-1:0] f1, f3, f4, f5a, f5b;
    f1  = 64'hD000_C000_B000_A000;
    f3  = 64'h0D0D_0C0C_0B0B_0A0A;
    f4  = 64'h2468_1357_DEF0_9ABC;
    f5a = 64'h1004_1003_1002_1001;
    f5b = 64'h1008_1007_1006_1005;

    // Reset, then words before any sync must be dropped
    add(1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 64'h0);
    add(1'b1, 1'b1, 1'b1, 16'h7777, 4'b0000, 1'b0, 1'b0, 1'b0, 64'h0);
    add(1'b0, 1'b1, 1'b0, 16'h1111, 4'b0000, 1'b0, 1'b0, 1'b0, 64'h0);
    add(1'b0, 1'b1, 1'b0, 16'h2222, 4'b0000, 1'b0, 1'b0, 1'b0, 64'h0);
    // Clean frame
    add(1'b0, 1'b1, 1'b1, 16'hA000, 4'b0001, 1'b0, 1'b0, 1'b1, 64'h0);
    add(1'b0, 1'b1, 1'b0, 16'hB000, 4'b0010, 1'b0, 1'b0, 1'b1, 64'h0);
    add(1'b0, 1'b1, 1'b0, 16'hC000, 4'b0100, 1'b0, 1'b0, 1'b1, 64'h0);
    add(1'b0, 1'b1, 1'b0, 16'hD000, 4'b1000, 1'b1, 1'b0, 1'b0, f1);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, f1);
    // Unsynced words after a frame are dropped too
    add(1'b0, 1'b1, 1'b0, 16'h1111, 4'b0000, 1'b0, 1'b0, 1'b0, f1);
    // Gapped frame with a frame_start while din_valid is low
    add(1'b0, 1'b1, 1'b1, 16'h0A0A, 4'b0001, 1'b0, 1'b0, 1'b1, f1);
    add_gaps(f1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 16'h0B0B, 4'b0010, 1'b0, 1'b0, 1'b1, f1);
    add_gaps(f1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 16'h0C0C, 4'b0100, 1'b0, 1'b0, 1'b1, f1);
    add_gaps(f1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 16'h0D0D, 4'b1000, 1'b1, 1'b0, 1'b0, f3);
    // Mid-frame resync
    add(1'b0, 1'b1, 1'b1, 16'h1234, 4'b0001, 1'b0, 1'b0, 1'b1, f3);
    add(1'b0, 1'b1, 1'b0, 16'h5678, 4'b0010, 1'b0, 1'b0, 1'b1, f3);
    add(1'b0, 1'b1, 1'b1, 16'h9ABC, 4'b0001, 1'b0, 1'b1, 1'b1, f3);
    add(1'b0, 1'b1, 1'b0, 16'hDEF0, 4'b0010, 1'b0, 1'b0, 1'b1, f3);
    add(1'b0, 1'b1, 1'b0, 16'h1357, 4'b0100, 1'b0, 1'b0, 1'b1, f3);
    add(1'b0, 1'b1, 1'b0, 16'h2468, 4'b1000, 1'b1, 1'b0, 1'b0, f4);
    // Back-to-back frames, zero bubble
    add(1'b0, 1'b1, 1'b1, 16'h1001, 4'b0001, 1'b0, 1'b0, 1'b1, f4);
    add(1'b0, 1'b1, 1'b0, 16'h1002, 4'b0010, 1'b0, 1'b0, 1'b1, f4);
    add(1'b0, 1'b1, 1'b0, 16'h1003, 4'b0100, 1'b0, 1'b0, 1'b1, f4);
    add(1'b0, 1'b1, 1'b0, 16'h1004, 4'b1000, 1'b1, 1'b0, 1'b0, f5a);
    add(1'b0, 1'b1, 1'b1, 16'h1005, 4'b0001, 1'b0, 1'b0, 1'b1, f5a);
    add(1'b0, 1'b1, 1'b0, 16'h1006, 4'b0010, 1'b0, 1'b0, 1'b1, f5a);
    add(1'b0, 1'b1, 1'b0, 16'h1007, 4'b0100, 1'b0, 1'b0, 1'b1, f5a);
    add(1'b0, 1'b1, 1'b0, 16'h1008, 4'b1000, 1'b1, 1'b0, 1'b0, f5b);
    // Reset mid-frame discards the partial frame
    add(1'b0, 1'b1, 1'b1, 16'h3001, 4'b0001, 1'b0, 1'b0, 1'b1, f5b);
    add(1'b0, 1'b1, 1'b0, 16'h3002, 4'b0010, 1'b0, 1'b0, 1'b1, f5b);
    add(1'b1, 1'b1, 1'b0, 16'h3003, 4'b0000, 1'b0, 1'b0, 1'b0, 64'h0);
    add(1'b0, 1'b1, 1'b0, 16'h3004, 4'b0000, 1'b0, 1'b0, 1'b0, 64'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].fs, tbl[i].d);
      chk("tbl_ch_valid", 64'(ch_valid), 64'(tbl[i].cv));
      chk("tbl_frame_done", 64'(frame_done), 64'(tbl[i].dn));
      chk("tbl_sync_err", 64'(sync_err), 64'(tbl[i].er));
      chk("tbl_busy", 64'(busy), 64'(tbl[i].b));
      chk("tbl_frame_out", frame_out, tbl[i].fr);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
           W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
